// File: rtl/i2c_target_port.sv
// i2c_target_port: I2C target engine oversampled by the system clock.
// Detects START/STOP, ACKs OWN_ADDR only, strobes out written bytes and
// serializes bytes fetched from the fabric on reads. SCL is never used as a clock.
module i2c_target_port #(
  parameter logic [6:0] OWN_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       addr_hit
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_hist;
  logic                   r_sda_hist;

  logic w_scl, w_sda;
  logic w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  state_t     r_state;
  logic [2:0] r_bitcnt;
  logic       r_full;      // 8 bits shifted in, waiting for the closing scl_fall
  logic       r_rw;        // latched R/W bit of the matched address byte
  logic [7:0] r_shift;
  logic [6:0] r_tx_shift;  // remaining read bits; bit 7 is driven at load time
  logic       r_sda_oe;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_tx_req;
  logic       r_busy;
  logic       r_addr_hit;

  // Metastability synchronizers plus one history flop per pin (data path, no reset)
  always_ff @(posedge clk) begin
    r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
    r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
    r_scl_hist <= r_scl_sync[SYNC_STAGES-1];
    r_sda_hist <= r_sda_sync[SYNC_STAGES-1];
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise =  w_scl & ~r_scl_hist;
  assign w_scl_fall = ~w_scl &  r_scl_hist;
  assign w_sda_rise =  w_sda & ~r_sda_hist;
  assign w_sda_fall = ~w_sda &  r_sda_hist;
  assign w_start    = w_sda_fall & w_scl;
  assign w_stop     = w_sda_rise & w_scl;

  // Protocol FSM: bus conditions first, then the one-cycle tx load, then per-state bit handling
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bitcnt   <= 3'd0;
      r_full     <= 1'b0;
      r_rw       <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_busy     <= 1'b0;
      r_addr_hit <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_addr_hit <= 1'b0;
      if (w_start) begin
        r_state  <= S_ADDR;
        r_bitcnt <= 3'd0;
        r_full   <= 1'b0;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_stop) begin
        r_state  <= S_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (r_tx_req) begin
        // tx_data is captured in the strobe cycle; SCL is still low here
        r_tx_shift <= tx_data[6:0];
        r_sda_oe   <= ~tx_data[7];
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift  <= {r_shift[6:0], w_sda};
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) r_full <= 1'b1;
            end else if (w_scl_fall && r_full) begin
              r_full <= 1'b0;
              if (r_shift[7:1] == OWN_ADDR) begin
                r_sda_oe   <= 1'b1;
                r_addr_hit <= 1'b1;
                r_busy     <= 1'b1;
                r_rw       <= r_shift[0];
                r_state    <= S_ADDR_ACK;
              end else begin
                r_state <= S_IGNORE;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bitcnt <= 3'd0;
              r_full   <= 1'b0;
              if (r_rw) begin
                r_tx_req <= 1'b1;
                r_state  <= S_RD_DATA;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= S_WR_DATA;
              end
            end
          end
          S_WR_DATA: begin
            if (w_scl_rise) begin
              r_shift  <= {r_shift[6:0], w_sda};
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_full     <= 1'b1;
                r_rx_data  <= {r_shift[6:0], w_sda};
                r_rx_valid <= 1'b1;
              end
            end else if (w_scl_fall && r_full) begin
              r_full   <= 1'b0;
              r_sda_oe <= 1'b1;
              r_state  <= S_WR_ACK;
            end
          end
          S_WR_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b0;
              r_bitcnt <= 3'd0;
              r_full   <= 1'b0;
              r_state  <= S_WR_DATA;
            end
          end
          S_RD_DATA: begin
            if (w_scl_fall) begin
              if (r_bitcnt == 3'd7) begin
                r_sda_oe <= 1'b0;
                r_bitcnt <= 3'd0;
                r_state  <= S_RD_ACK;
              end else begin
                r_sda_oe   <= ~r_tx_shift[6];
                r_tx_shift <= {r_tx_shift[5:0], 1'b0};
                r_bitcnt   <= r_bitcnt + 3'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (w_scl_rise && w_sda) begin
              r_busy  <= 1'b0;
              r_state <= S_IGNORE;
            end else if (w_scl_fall) begin
              r_tx_req <= 1'b1;
              r_bitcnt <= 3'd0;
              r_state  <= S_RD_DATA;
            end
          end
          S_IGNORE: r_sda_oe <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign sda_oe   = r_sda_oe;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_req   = r_tx_req;
  assign busy     = r_busy;
  assign addr_hit = r_addr_hit;

endmodule

// File: tb/tb_i2c_target_port.sv
// tb_i2c_target_port: bus-level initiator model driving i2c_target_port,
// with a transaction-level reference of ACKs, received bytes and strobe counts.
`timescale 1ns/1ps
module tb_i2c_target_port;

  localparam logic [6:0] OWN  = 7'h50;
  localparam int         SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_in = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req;
  logic       busy;
  logic       addr_hit;

  // open-drain bus: either side may pull low
  assign sda_in = m_sda & ~sda_oe;

  i2c_target_port #(.OWN_ADDR(OWN), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req),
    .busy(busy), .addr_hit(addr_hit)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // observed activity
  int         mon_hits = 0, mon_rx = 0, mon_tx = 0, mon_oe = 0, mon_coinc = 0;
  logic [7:0] mon_rx_q[$];
  // reference expectations
  int         exp_hits = 0, exp_rx = 0, exp_tx = 0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] dbuf[8];

  always @(negedge clk) begin
    if (addr_hit) mon_hits++;
    if (rx_valid) begin mon_rx++; mon_rx_q.push_back(rx_data); end
    if (tx_req) mon_tx++;
    if (sda_oe) mon_oe++;
    if ((rx_valid && tx_req) || (addr_hit && tx_req)) mon_coinc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (scl_in == 1'b0) begin
      clk_n(4); m_sda = 1'b1; clk_n(4); scl_in = 1'b1; clk_n(6);
    end else begin
      clk_n(6);
    end
    m_sda = 1'b0; clk_n(6); scl_in = 1'b0;
  endtask

  task automatic bus_stop();
    clk_n(4); m_sda = 1'b0; clk_n(4); scl_in = 1'b1; clk_n(6);
    m_sda = 1'b1; clk_n(SYNC + 2);
  endtask

  // acked = target held SDA low for the whole ACK high phase
  task automatic send_byte(input logic [7:0] b, input int rst_bit, output logic acked);
    for (int i = 7; i >= 0; i--) begin
      clk_n(4); m_sda = b[i]; clk_n(4); scl_in = 1'b1;
      if (i == rst_bit) begin
        clk_n(2); rst = 1'b1; clk_n(1); rst = 1'b0; clk_n(1);
        check1("rst_sda_oe", sda_oe, 1'b0);
        check1("rst_busy", busy, 1'b0);
        clk_n(2);
      end else begin
        clk_n(6);
      end
      scl_in = 1'b0;
    end
    clk_n(4); m_sda = 1'b1; clk_n(4); scl_in = 1'b1;
    acked = 1'b1;
    for (int k = 0; k < 6; k++) begin
      clk_n(1);
      if (sda_oe !== 1'b1 || sda_in !== 1'b0) acked = 1'b0;
    end
    scl_in = 1'b0;
  endtask

  task automatic recv_byte(input logic nack, input logic [7:0] next_tx, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      clk_n(4); m_sda = 1'b1; clk_n(4); scl_in = 1'b1;
      clk_n(3); b[i] = sda_in; clk_n(3); scl_in = 1'b0;
    end
    tx_data = next_tx;
    clk_n(4); m_sda = nack; clk_n(4); scl_in = 1'b1; clk_n(6); scl_in = 1'b0;
  endtask

  task automatic compare_counts();
    checkn("addr_hit_count", mon_hits, exp_hits);
    checkn("rx_valid_count", mon_rx, exp_rx);
    checkn("tx_req_count", mon_tx, exp_tx);
    while (mon_rx_q.size() > 0 && exp_rx_q.size() > 0)
      check8("rx_data", mon_rx_q.pop_front(), exp_rx_q.pop_front());
  endtask

  // one transaction: address byte then n data bytes from dbuf
  task automatic run_txn(input logic [6:0] a, input logic rw, input int n, input logic do_stop);
    logic       hit, ack;
    logic [7:0] got;
    int         oe0;
    hit = (a == OWN);
    oe0 = mon_oe;
    tx_data = dbuf[0];
    bus_start();
    send_byte({a, rw}, -1, ack);
    check1("addr_ack", ack, hit);
    if (hit) exp_hits++;
    for (int j = 0; j < n; j++) begin
      if (!rw) begin
        send_byte(dbuf[j], -1, ack);
        check1("wr_ack", ack, hit);
        if (hit) begin exp_rx++; exp_rx_q.push_back(dbuf[j]); end
      end else begin
        recv_byte(j == n - 1, dbuf[j+1], got);
        check8("rd_byte", got, hit ? dbuf[j] : 8'hFF);
        if (hit) exp_tx++;
      end
    end
    if (rw && hit) begin
      check1("nack_sda_oe", sda_oe, 1'b0);
      check1("nack_busy", busy, 1'b0);
    end
    if (!rw) check1("busy_before_stop", busy, hit);
    if (do_stop) begin
      bus_stop();
      check1("busy_after_stop", busy, 1'b0);
    end
    if (!hit) checkn("sda_oe_quiet", mon_oe - oe0, 0);
    compare_counts();
  endtask

  initial begin
    logic ack;
    logic [6:0] ra;
    clk_n(5);
    checkn("reset_flags", int'({sda_oe, rx_valid, tx_req, busy, addr_hit}), 0);
    check8("reset_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    clk_n(4);

    // write 0x3C to own address
    dbuf[0] = 8'h3C;
    run_txn(OWN, 1'b0, 1, 1'b1);

    // wrong address, then general call
    run_txn(7'h51, 1'b0, 1, 1'b1);
    dbuf[0] = 8'($urandom);
    run_txn(7'h00, 1'b0, 1, 1'b1);

    // read two bytes, ACK then NACK
    dbuf[0] = 8'h96; dbuf[1] = 8'h5A; dbuf[2] = 8'h00;
    run_txn(OWN, 1'b1, 2, 1'b1);

    // write 0x11, repeated START, read one byte
    dbuf[0] = 8'h11;
    run_txn(OWN, 1'b0, 1, 1'b0);
    dbuf[0] = 8'($urandom); dbuf[1] = 8'($urandom);
    run_txn(OWN, 1'b1, 1, 1'b1);

    // reset pulse during the 4th data bit of a write
    tx_data = 8'h00;
    bus_start();
    send_byte({OWN, 1'b0}, -1, ack);
    check1("rst_txn_addr_ack", ack, 1'b1);
    exp_hits++;
    send_byte(8'h3C, 4, ack);
    check1("rst_txn_data_ack", ack, 1'b0);
    bus_stop();
    check1("rst_txn_busy", busy, 1'b0);
    compare_counts();
    dbuf[0] = 8'h3C;
    run_txn(OWN, 1'b0, 1, 1'b1);

    // back-to-back multi-byte write
    dbuf[0] = 8'h00; dbuf[1] = 8'hFF; dbuf[2] = 8'hA5;
    run_txn(OWN, 1'b0, 3, 1'b1);

    // randomized transactions
    for (int t = 0; t < 8; t++) begin
      ra = ($urandom_range(0, 1) == 1) ? OWN : 7'($urandom_range(0, 127));
      for (int j = 0; j < 8; j++) dbuf[j] = 8'($urandom);
      run_txn(ra, 1'($urandom_range(0, 1)), int'($urandom_range(1, 4)), 1'b1);
    end

    checkn("strobe_coincidence", mon_coinc, 0);
    checkn("rx_queue_drained", mon_rx_q.size(), exp_rx_q.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
